// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 24;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } s1_t;

    localparam s1_t S1_IDLE = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM pin bundle; slave side is the arbiter, master side the environment.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              REQ0;
    logic              REQ1;
    logic              WR0;
    logic              WR1;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA0;
    logic [DATA_W-1:0] WDATA1;
    logic              GNT0;
    logic              GNT1;
    logic              RVALID0;
    logic              RVALID1;
    logic [DATA_W-1:0] RDATA0;
    logic [DATA_W-1:0] RDATA1;
    logic [ADDR_W-1:0] RAM_A;
    logic              RAM_WE;
    logic              RAM_OE;
    logic [DATA_W-1:0] RAM_D;
    logic [DATA_W-1:0] RAM_Q;

    modport slave (
        input  REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_Q,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
               RAM_A, RAM_WE, RAM_OE, RAM_D
    );

    modport master (
        output REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_Q,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
               RAM_A, RAM_WE, RAM_OE, RAM_D
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; owns the last-granted-port register.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_gnt;

    // One-hot grant; on a tie the port that did not win last time goes first.
    always_comb begin
        w_gnt = 2'b00;
        if (!i_rst_n) begin
            w_gnt = 2'b00;
        end else begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last == PORT_DMA) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Remember the winner; reset to the DMA port so the CPU wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= PORT_DMA;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end else begin
            r_last <= r_last;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port synchronous RAM between CPU and DMA requesters with a
// fixed two-cycle read return path.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic          CK,
    input  logic          RST_N,
    ram_arbiter_if.slave  bus
);

    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_ram_a;
    logic [DATA_W-1:0] w_ram_d;
    logic              w_we;
    logic              w_rd;
    s1_t               r_s1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    rr_arb2 u_arb (
        .i_clk   (CK),
        .i_rst_n (RST_N),
        .i_req   ({bus.REQ1, bus.REQ0}),
        .o_gnt   (w_gnt)
    );

    // Winner's address/data to the RAM pins; port 0 parks there when idle.
    always_comb begin
        w_ram_a = bus.ADDR0;
        w_ram_d = bus.WDATA0;
        w_we    = 1'b0;
        w_rd    = 1'b0;
        if (w_gnt[PORT_DMA]) begin
            w_ram_a = bus.ADDR1;
            w_ram_d = bus.WDATA1;
            w_we    = bus.WR1;
            w_rd    = ~bus.WR1;
        end else if (w_gnt[PORT_CPU]) begin
            w_we    = bus.WR0;
            w_rd    = ~bus.WR0;
        end else begin
            w_we    = 1'b0;
            w_rd    = 1'b0;
        end
    end

    // S1 marks the cycle the RAM drives Q for a read granted one cycle earlier.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1 <= S1_IDLE;
        end else begin
            r_s1 <= '{valid: w_rd, id: w_gnt[PORT_DMA]};
        end
    end

    // Capture Q into the owner's data register; the strobe lasts one cycle.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= {DATA_W{1'b0}};
            r_rdata1  <= {DATA_W{1'b0}};
        end else begin
            r_rvalid0 <= r_s1.valid && (r_s1.id == PORT_CPU);
            r_rvalid1 <= r_s1.valid && (r_s1.id == PORT_DMA);
            if (r_s1.valid && (r_s1.id == PORT_CPU)) begin
                r_rdata0 <= bus.RAM_Q;
            end else begin
                r_rdata0 <= r_rdata0;
            end
            if (r_s1.valid && (r_s1.id == PORT_DMA)) begin
                r_rdata1 <= bus.RAM_Q;
            end else begin
                r_rdata1 <= r_rdata1;
            end
        end
    end

    assign bus.GNT0    = w_gnt[PORT_CPU];
    assign bus.GNT1    = w_gnt[PORT_DMA];
    assign bus.RAM_A   = w_ram_a;
    assign bus.RAM_D   = w_ram_d;
    assign bus.RAM_WE  = w_we;
    assign bus.RAM_OE  = r_s1.valid;
    assign bus.RVALID0 = r_rvalid0;
    assign bus.RVALID1 = r_rvalid1;
    assign bus.RDATA0  = r_rdata0;
    assign bus.RDATA1  = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64K x 24 synchronous RAM.
module tb_ram_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] mem [0:65535];
    logic [15:0] lat_a = 16'h0000;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(24)) bus ();

    ram_arbiter #(.ADDR_W(16), .DATA_W(24)) dut (
        .CK    (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM: write and address latch on the clock edge, Q follows the latched address.
    always @(posedge clk) begin
        if (bus.RAM_WE) mem[bus.RAM_A] <= bus.RAM_D;
        lat_a <= bus.RAM_A;
    end
    assign bus.RAM_Q = mem[lat_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [15:0] a0, input logic [23:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [23:0] d1);
        bus.REQ0 = r0; bus.WR0 = w0; bus.ADDR0 = a0; bus.WDATA0 = d0;
        bus.REQ1 = r1; bus.WR1 = w1; bus.ADDR1 = a1; bus.WDATA1 = d1;
    endtask

    task automatic idle_in();
        drv(1'b0, 1'b0, 16'h0000, 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h5A0000 | 24'(i);

        // Reset: grants and WE gated even with a request present.
        drv(1'b1, 1'b1, 16'h0040, 24'h123456, 1'b1, 1'b0, 16'h0041, 24'h000000);
        #1 rst_n = 1'b0;
        mid();
        chk("rst_gnt_we", {29'd0, bus.GNT1, bus.GNT0, bus.RAM_WE}, 32'd0);
        chk("rst_oe_rv", {29'd0, bus.RAM_OE, bus.RVALID1, bus.RVALID0}, 32'd0);
        chk("rst_rdata0", {8'd0, bus.RDATA0}, 32'd0);
        idle_in();
        nxt();
        rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("idle", {26'd0, bus.RAM_WE, bus.RAM_OE, bus.GNT1, bus.GNT0, bus.RVALID1, bus.RVALID0}, 32'd0);
            nxt();
        end

        // Contention: both ports read for 8 cycles; port 0 wins first.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drv(1'b1, 1'b0, 16'h0010, 24'h000000, 1'b1, 1'b0, 16'h0020, 24'h000000);
            else idle_in();
            mid();
            if (k < 8) chk("ct_gnt", {30'd0, bus.GNT1, bus.GNT0}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k >= 2) begin
                if ((k - 2) % 2 == 0) begin
                    chk("ct_rv0", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd1);
                    chk("ct_rd0", {8'd0, bus.RDATA0}, 32'h005A0010);
                end else begin
                    chk("ct_rv1", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd2);
                    chk("ct_rd1", {8'd0, bus.RDATA1}, 32'h005A0020);
                end
            end
            nxt();
        end

        // Port 0 write then read of 0x1234.
        drv(1'b1, 1'b1, 16'h1234, 24'hABCDEF, 1'b0, 1'b0, 16'h0000, 24'h000000);
        mid();
        chk("t1_wr", {29'd0, bus.GNT1, bus.GNT0, bus.RAM_WE}, 32'b011);
        chk("t1_a", {16'd0, bus.RAM_A}, 32'h00001234);
        chk("t1_d", {8'd0, bus.RAM_D}, 32'h00ABCDEF);
        nxt();
        drv(1'b1, 1'b0, 16'h1234, 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000);
        mid();
        chk("t1_rg", {28'd0, bus.GNT1, bus.GNT0, bus.RAM_WE, bus.RAM_OE}, 32'b0100);
        nxt();
        idle_in();
        mid();
        chk("t1_oe", {29'd0, bus.RAM_OE, bus.RVALID1, bus.RVALID0}, 32'b100);
        nxt();
        mid();
        chk("t1_rv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b01);
        chk("t1_rd", {8'd0, bus.RDATA0}, 32'h00ABCDEF);
        nxt();
        mid();
        chk("t1_hold", {6'd0, bus.RVALID1, bus.RVALID0, bus.RDATA0}, {8'd0, 24'hABCDEF});
        nxt();

        // Port 1 write then immediate read of the same address.
        drv(1'b0, 1'b0, 16'h0000, 24'h000000, 1'b1, 1'b1, 16'h0005, 24'h000111);
        mid();
        chk("t3_wr", {29'd0, bus.GNT1, bus.GNT0, bus.RAM_WE}, 32'b101);
        nxt();
        drv(1'b0, 1'b0, 16'h0000, 24'h000000, 1'b1, 1'b0, 16'h0005, 24'h000000);
        mid();
        chk("t3_rg", {29'd0, bus.GNT1, bus.GNT0, bus.RAM_WE}, 32'b100);
        nxt();
        idle_in();
        nxt();
        mid();
        chk("t3_rv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b10);
        chk("t3_rd", {8'd0, bus.RDATA1}, 32'h00000111);
        nxt();

        // Port 0 read followed by a port 1 write to the same address: old data returns.
        drv(1'b1, 1'b0, 16'h0030, 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000);
        mid();
        chk("war_g0", {30'd0, bus.GNT1, bus.GNT0}, 32'b01);
        nxt();
        drv(1'b0, 1'b0, 16'h0000, 24'h000000, 1'b1, 1'b1, 16'h0030, 24'h777777);
        mid();
        chk("war_g1", {28'd0, bus.GNT1, bus.GNT0, bus.RAM_WE, bus.RAM_OE}, 32'b1011);
        nxt();
        idle_in();
        mid();
        chk("war_rv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b01);
        chk("war_rd", {8'd0, bus.RDATA0}, 32'h005A0030);
        nxt();

        // Pipelined reads on port 0.
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drv(1'b1, 1'b0, 16'(k), 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000);
            else idle_in();
            mid();
            if (k < 3) chk("pl_gnt", {30'd0, bus.GNT1, bus.GNT0}, 32'b01);
            if (k >= 2 && k < 5) begin
                chk("pl_rv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b01);
                chk("pl_rd", {8'd0, bus.RDATA0}, 32'h005A0000 + 32'(k - 2));
            end
            if (k == 5) chk("pl_end", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b00);
            nxt();
        end

        // Reset during an in-flight read.
        drv(1'b1, 1'b0, 16'h0001, 24'h000000, 1'b0, 1'b0, 16'h0000, 24'h000000);
        mid();
        chk("rm_g0", {30'd0, bus.GNT1, bus.GNT0}, 32'b01);
        nxt();
        idle_in();
        rst_n = 1'b0;
        mid();
        chk("rm_oe_rv", {29'd0, bus.RAM_OE, bus.RVALID1, bus.RVALID0}, 32'd0);
        chk("rm_rdata0", {8'd0, bus.RDATA0}, 32'd0);
        #2 rst_n = 1'b1;
        nxt();
        drv(1'b1, 1'b0, 16'h0003, 24'h000000, 1'b1, 1'b0, 16'h0004, 24'h000000);
        mid();
        chk("rm_norv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd0);
        chk("rm_rd0", {8'd0, bus.RDATA0}, 32'd0);
        chk("rm_tie", {30'd0, bus.GNT1, bus.GNT0}, 32'b01);
        nxt();
        idle_in();
        mid();
        chk("rm_rv_lat", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd0);
        nxt();
        mid();
        chk("rm_rv", {30'd0, bus.RVALID1, bus.RVALID0}, 32'b01);
        chk("rm_rd", {8'd0, bus.RDATA0}, 32'h005A0003);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and access sequencer for the 64K x 24 single-port synchronous RAM of the mini system. It shares the RAM between requester 0 (CPU) and requester 1 (DMA/host loader). It accepts at most one access per cycle, drives the RAM's A/WE/OE/D pins, and returns read data to the owning requester with fixed latency. Write commits and address latching happen at the RAM's CK edge; read data appears on RAM Q while OE is high in the cycle after address latch.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 24, RAM data width

Ports:
- CK  in  1  system clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  access request, held until granted
- WR0 / WR1  in  1  1 = write, 0 = read; sampled with REQx
- ADDR0 / ADDR1  in  ADDR_W  access address
- WDATA0 / WDATA1  in  DATA_W  write data
- GNT0 / GNT1  out  1  combinational accept pulse; request consumed at this cycle's edge
- RVALID0 / RVALID1  out  1  registered one-cycle read-data strobe
- RDATA0 / RDATA1  out  DATA_W  registered read data, held until next RVALIDx
- RAM_A  out  ADDR_W  to RAM A
- RAM_WE  out  1  to RAM WE
- RAM_OE  out  1  to RAM OE, registered
- RAM_D  out  DATA_W  to RAM D
- RAM_Q  in  DATA_W  from RAM Q

## Operation
- Arbitration: each cycle, if exactly one REQx is high, grant it. If both are high, grant the port other than LAST. LAST is a 1-bit register updated to the granted port on every grant; its reset value is 1, so port 0 wins the first tie.
- At most one GNT per cycle. GNT0 & GNT1 is never 1.
- Granted port muxed combinationally onto RAM_A and RAM_D. RAM_WE = grant & WR of the winner. With no grant: RAM_WE=0; RAM_A and RAM_D hold the port-0 values, which is harmless because the RAM only latches an address.
- Read pipeline:
  - S1 register {valid, id} loads on a read grant.
  - While S1.valid: RAM_OE=1.
  - At the end of that cycle RAM_Q is captured into RDATA[id], and RVALID[id]=1 for the following cycle.
- Grants may issue every cycle, including back-to-back reads, mixed ports, and a write directly after a read. RAM latched_A changing under an in-flight S1 is safe, because Q is sampled in the same cycle OE is asserted.
- Read-after-write to the same address in consecutive grants returns the new data, since the write commits at the grant edge.
- No ordering is guaranteed between ports. Per port, responses return in grant order.

## Timing
- Write: grant in cycle N, memory updated at edge N+1, no response.
- Read: grant in cycle N, address latched at edge N+1, RAM_OE=1 during N+1, RDATA/RVALID valid during N+2. Fixed latency is 2 cycles from grant to RVALID.
- Throughput: 1 access/cycle. With continuous requests on both ports, grants strictly alternate.
- Reset (RST_N low, async):
  - S1.valid=0, RAM_OE=0, RVALID0/1=0, RDATA0/1=0, LAST=1.
  - GNT0/1=0 and RAM_WE=0 while RST_N is low (gated combinationally).
  - An in-flight read is dropped and no RVALID is produced.
  - The first grant is possible in the first cycle after release.
- REQx dropping without GNT is legal: nothing is issued and LAST is unchanged.

## Structure
- Package ram_arb_pkg:
  - ADDR_W/DATA_W defaults
  - port-id constants PORT_CPU=0, PORT_DMA=1
  - S1 pipeline record type {valid, id}
- Sub-module rr_arb2:
  - inputs: two requests, LAST
  - output: one-hot grant
  - owns the LAST register
- ram_arbiter holds the muxes, the S1 stage and the response registers.

## Test plan
- Single write then read, port 0: write 0x1234 <- 0xABCDEF, then read 0x1234 → RVALID0 exactly 2 cycles after read GNT0, RDATA0=0xABCDEF, RVALID1 stays 0.
- Contention: both ports request reads continuously for 8 cycles → grants alternate 0,1,0,1…, first GNT0. Each RVALIDx carries its own address's data at fixed latency.
- Back-to-back: port 1 writes 0x0005 <- 0x000111, then reads 0x0005 the next cycle → RDATA1=0x000111.
- Pipelined reads: port 0 reads 0x0000, 0x0001, 0x0002 on consecutive cycles → three consecutive RVALID0 cycles with data in order.
- Reset mid-read: read granted at cycle N, RST_N pulsed low during N+1 → no RVALID. RAM_OE/RDATA are 0, and the next tie goes to port 0.
- Idle: no REQ for 10 cycles → RAM_WE=0, RAM_OE=0, no GNT, no RVALID.
